// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants, pointer type and occupancy helper for the FIFO controller.
package fifo_pkg;
    localparam int unsigned ADDR_WIDTH_DEF = 2;
    typedef logic [ADDR_WIDTH_DEF:0] ptr_t;
    // Pointer difference modulo 2**(aw+1); the wrap bit makes a full FIFO distinct from empty.
    function automatic logic [31:0] ptr_diff(input logic [31:0] w, input logic [31:0] r, input int unsigned aw);
        ptr_diff = (w - r) & ((32'd1 << (aw + 1)) - 32'd1);
    endfunction
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: W-bit wrapping pointer with increment enable.
// Ports: clk, rst_n (sync active-low), en (advance by one), ptr (current value).
module fifo_ptr #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] ptr
);
    logic [W-1:0] ptr_d, ptr_q;
    always_comb ptr_d = en ? ptr_q + 1'b1 : ptr_q;
    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
    assign ptr = ptr_q;
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller for a register-file FIFO.
// Ports: clk, rst_n (sync active-low), wr/rd strobes, clr_err; wr_en, w_addr, r_addr to the
// register file; full, empty, almost_full, almost_empty, count, sticky overflow/underflow.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned AF_LEVEL   = 3,
    parameter int unsigned AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam logic [ADDR_WIDTH:0] AF = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE = AE_LEVEL[ADDR_WIDTH:0];
    logic [ADDR_WIDTH:0] w_ptr, r_ptr;
    logic do_wr, do_rd;
    logic ovf_d, ovf_q, unf_d, unf_q;
    fifo_ptr #(.W(ADDR_WIDTH + 1)) u_wptr (.clk(clk), .rst_n(rst_n), .en(do_wr), .ptr(w_ptr));
    fifo_ptr #(.W(ADDR_WIDTH + 1)) u_rptr (.clk(clk), .rst_n(rst_n), .en(do_rd), .ptr(r_ptr));
    always_comb begin
        empty        = (w_ptr == r_ptr);
        full         = (w_ptr[ADDR_WIDTH] != r_ptr[ADDR_WIDTH]) &&
                       (w_ptr[ADDR_WIDTH-1:0] == r_ptr[ADDR_WIDTH-1:0]);
        count        = (ADDR_WIDTH + 1)'(ptr_diff(32'(w_ptr), 32'(r_ptr), ADDR_WIDTH));
        almost_full  = (count >= AF);
        almost_empty = (count <= AE);
        // A simultaneous pop frees the head slot, so a push into a full FIFO may proceed.
        do_wr        = wr & (~full | rd);
        do_rd        = rd & ~empty;
        wr_en        = do_wr & rst_n;
        // A new drop takes priority over a coincident clear.
        ovf_d        = (wr & ~do_wr) | (ovf_q & ~clr_err);
        unf_d        = (rd & ~do_rd) | (unf_q & ~clr_err);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end
    assign w_addr    = w_ptr[ADDR_WIDTH-1:0];
    assign r_addr    = r_ptr[ADDR_WIDTH-1:0];
    assign overflow  = ovf_q;
    assign underflow = unf_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed self-checking bench for fifo_ctrl (ADDR_WIDTH=2, AF=3, AE=1).
module tb_fifo_ctrl;
    logic clk = 1'b0, rst_n, wr, rd, clr_err;
    logic wr_en, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [1:0] w_addr, r_addr;
    logic [2:0] count;
    int n_cmp = 0, n_err = 0;

    fifo_ctrl #(.ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .clr_err(clr_err),
        .wr_en(wr_en), .w_addr(w_addr), .r_addr(r_addr), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
        tick(); tick();
        wr = 1'b1; #1;
        chk("wr_en_in_reset", {31'd0, wr_en}, 0);
        wr = 1'b0; rst_n = 1'b1; #1;
        chk("rst_empty", {31'd0, empty}, 1);
        chk("rst_full", {31'd0, full}, 0);
        chk("rst_count", {29'd0, count}, 0);
        chk("rst_ae", {31'd0, almost_empty}, 1);
        chk("rst_af", {31'd0, almost_full}, 0);
        chk("rst_waddr", {30'd0, w_addr}, 0);
        chk("rst_raddr", {30'd0, r_addr}, 0);
        chk("rst_wr_en", {31'd0, wr_en}, 0);
        for (int i = 0; i < 4; i++) begin
            wr = 1'b1; #1;
            chk("fill_wr_en", {31'd0, wr_en}, 1);
            chk("fill_waddr", {30'd0, w_addr}, i);
            tick();
            chk("fill_count", {29'd0, count}, i + 1);
            chk("fill_af", {31'd0, almost_full}, (i + 1 >= 3) ? 1 : 0);
            chk("fill_ae", {31'd0, almost_empty}, (i + 1 <= 1) ? 1 : 0);
        end
        wr = 1'b0; #1;
        chk("full_flag", {31'd0, full}, 1);
        chk("full_waddr", {30'd0, w_addr}, 0);
        chk("full_empty", {31'd0, empty}, 0);
        wr = 1'b1; #1;
        chk("ovf_wr_en", {31'd0, wr_en}, 0);
        tick();
        wr = 1'b0; #1;
        chk("ovf_set", {31'd0, overflow}, 1);
        chk("ovf_count", {29'd0, count}, 4);
        chk("ovf_waddr", {30'd0, w_addr}, 0);
        chk("ovf_raddr", {30'd0, r_addr}, 0);
        tick();
        chk("ovf_sticky", {31'd0, overflow}, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0; #1;
        chk("ovf_clr", {31'd0, overflow}, 0);
        wr = 1'b1; rd = 1'b1; #1;
        chk("fwr_wr_en", {31'd0, wr_en}, 1);
        chk("fwr_raddr", {30'd0, r_addr}, 0);
        chk("fwr_waddr", {30'd0, w_addr}, 0);
        tick();
        wr = 1'b0; rd = 1'b0; #1;
        chk("fwr_raddr_nx", {30'd0, r_addr}, 1);
        chk("fwr_waddr_nx", {30'd0, w_addr}, 1);
        chk("fwr_full", {31'd0, full}, 1);
        chk("fwr_count", {29'd0, count}, 4);
        chk("fwr_no_ovf", {31'd0, overflow}, 0);
        for (int i = 0; i < 4; i++) begin
            rd = 1'b1; #1;
            chk("drain_raddr", {30'd0, r_addr}, (i + 1) % 4);
            tick();
            chk("drain_count", {29'd0, count}, 3 - i);
        end
        rd = 1'b0; #1;
        chk("drain_empty", {31'd0, empty}, 1);
        chk("drain_unf0", {31'd0, underflow}, 0);
        rd = 1'b1;
        tick();
        rd = 1'b0; #1;
        chk("unf_set", {31'd0, underflow}, 1);
        chk("unf_raddr", {30'd0, r_addr}, 1);
        chk("unf_waddr", {30'd0, w_addr}, 1);
        chk("unf_count", {29'd0, count}, 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0; #1;
        chk("unf_clr", {31'd0, underflow}, 0);
        clr_err = 1'b1; rd = 1'b1;
        tick();
        clr_err = 1'b0; rd = 1'b0; #1;
        chk("unf_set_wins", {31'd0, underflow}, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0; #1;
        chk("unf_clr2", {31'd0, underflow}, 0);
        wr = 1'b1; rd = 1'b1; #1;
        chk("ewr_wr_en", {31'd0, wr_en}, 1);
        tick();
        rd = 1'b0; #1;
        chk("ewr_count", {29'd0, count}, 1);
        chk("ewr_unf", {31'd0, underflow}, 1);
        chk("ewr_empty", {31'd0, empty}, 0);
        tick();
        wr = 1'b0; #1;
        chk("pre_rst_count", {29'd0, count}, 2);
        rst_n = 1'b0; wr = 1'b1; rd = 1'b1;
        tick();
        rst_n = 1'b1; wr = 1'b0; rd = 1'b0; #1;
        chk("mid_rst_count", {29'd0, count}, 0);
        chk("mid_rst_empty", {31'd0, empty}, 1);
        chk("mid_rst_ovf", {31'd0, overflow}, 0);
        chk("mid_rst_unf", {31'd0, underflow}, 0);
        chk("mid_rst_waddr", {30'd0, w_addr}, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
